up_count: RTL and testbench
===========================

# up_count

Free-running decimal up-counter that advances a 4-bit BCD units digit on a programmable tick and cascades into a tens digit. It sits in the clock domain of `CLK` as a basic timebase/display-count source. Its `units` output drives digit decoders or downstream logic. With default parameters it counts one step per clock edge: 0,1,…,9,0,…

## Interface
Parameters:
- `DIV`, default 1: prescale ratio. The count advances once every `DIV` clock cycles. Legal range 1..65536.
- `MAX`, default 9: terminal value of `units`. Legal range 1..15. `units` wraps from `MAX` to 0.

Ports:
- `CLK`, input, 1: single clock. All state updates on its rising edge.
- `RST`, input, 1: reset, synchronous and active-high.
- `units`, output, 4: units digit, registered.
- `tens`, output, 4: tens digit, BCD 0..9, registered.
- `carry`, output, 1: one-cycle pulse marking a `units` wrap, registered.

## Operation
- Internal prescaler `pre` is ceil(log2(DIV)) bits wide, minimum 1 bit.
  - On each edge, `pre` counts 0..DIV-1 and wraps to 0.
  - `tick` is asserted when `pre == DIV-1`. With DIV=1, `tick` is constantly 1.
- On an edge with `tick=1` and `RST=0`:
  - If `units < MAX`: `units <= units+1`, `tens` holds, `carry <= 0`.
  - If `units == MAX`: `units <= 0`, `carry <= 1`, and `tens` advances as follows.
    - If `tens < 9`: `tens <= tens+1`.
    - If `tens == 9`: `tens <= 0`.
- On an edge with `tick=0` and `RST=0`: `units` and `tens` hold, `carry <= 0`.
- Out-of-range states can only arise from an upset or from an illegal `MAX` change:
  - If `units > MAX` on a tick, it wraps to 0 exactly as at `MAX`, including `carry` and the `tens` advance.
  - If `tens > 9` when `tens` must advance, it goes to 0.
- All arithmetic is 4-bit unsigned. No signed values. No intermediate value exceeds 4 bits.
- No enable or load inputs. The counter is always running when out of reset.

## Timing
- Reset values: `units=0`, `tens=0`, `carry=0`, `pre=0`.
- Reset is synchronous. `RST` sampled high at an edge forces all reset values at that edge. It has priority over `tick` and over any wrap.
- Reset mid-count: takes effect at the next edge regardless of state, including `units==MAX` with `tick=1`. No `carry` is produced at that edge.
- First edge with `RST` low:
  - DIV=1: `units` becomes 1.
  - General case: `units` first becomes 1 at the DIV-th edge after reset release.
- Latency: outputs change on the tick edge itself. There is no extra pipeline stage. `carry` is high during exactly the cycle in which `units` reads 0 after a wrap.
- Steady-state period:
  - `units` sequence repeats every (MAX+1)·DIV cycles.
  - `tens` sequence repeats every 10·(MAX+1)·DIV cycles.
- Before the first reset, output values are undefined. The bench must apply `RST` before checking.

## Test plan
- Reset: DIV=1, MAX=9. Hold `RST=1` for 3 edges -> `units=0`, `tens=0`, `carry=0` after the first edge with `RST` high. Release `RST` -> `units` reads 1,2,…,9,0 on successive edges.
- Wrap and carry: DIV=1, MAX=9, run 10 edges after reset -> `units` goes 9→0 on edge 10, `carry=1` for that single cycle only, `tens=1`.
- Tens wrap: DIV=1, MAX=9, run 100 edges after reset -> `tens` goes 9→0 and `units=0` at edge 100, `carry=1` for that cycle.
- Prescale: DIV=4, MAX=9 -> `units` increments only at edges 4, 8, 12… after reset release. At edge 40: `units=0`, `tens=1`, `carry` high for one cycle.
- Non-decimal terminal: DIV=1, MAX=5 -> `units` sequence 0,1,2,3,4,5,0. `tens=1` after 6 edges.
- Reset mid-operation: DIV=1, assert `RST` when `units=9`, `tens=3` -> next edge gives `units=0`, `tens=0`, `carry=0`. Counting resumes from 1 after release.

Source files
------------

// File: rtl/up_count.sv
// up_count: free-running decimal counter with a programmable prescaler.
// A units digit advances once every DIV clocks, wraps after MAX and
// cascades into a BCD tens digit. carry pulses for the cycle that follows a wrap.
module up_count #(
    parameter int unsigned DIV = 1,
    parameter int unsigned MAX = 9
) (
    input  logic       CLK,
    input  logic       RST,
    output logic [3:0] units,
    output logic [3:0] tens,
    output logic       carry
);

    // Prescaler is ceil(log2(DIV)) bits wide, but never narrower than one bit.
    localparam int unsigned      PRE_W      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(DIV - 1);
    localparam logic [3:0]       UNITS_LAST = 4'(MAX);
    localparam logic [3:0]       TENS_LAST  = 4'd9;

    // Reject parameter values the 4-bit datapath and 16-bit prescaler cannot hold.
    if (DIV < 1 || DIV > 65536) begin : g_bad_div
        $error("up_count: DIV must be in 1..65536");
    end
    if (MAX < 1 || MAX > 15) begin : g_bad_max
        $error("up_count: MAX must be in 1..15");
    end

    logic [PRE_W-1:0] pre;
    logic             tick;
    logic             units_wrap;
    logic             tens_wrap;

    // With DIV=1 the prescaler is stuck at 0, which equals PRE_LAST, so tick is constantly high.
    assign tick = (pre == PRE_LAST);

    // ">=" rather than "==": an upset value above the terminal count
    // recovers through the normal wrap path instead of running up to 15.
    assign units_wrap = (units >= UNITS_LAST);
    assign tens_wrap  = (tens >= TENS_LAST);

    // Prescaler: count 0..DIV-1 and restart, generating one tick per period.
    always_ff @(posedge CLK) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (RST) begin
            pre <= '0;
        end else if (tick) begin
            pre <= '0;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    // Digit counters: reset beats tick, and carry is registered together with the wrap.
    always_ff @(posedge CLK) begin
        if (RST) begin
            units <= 4'd0;
            tens  <= 4'd0;
            carry <= 1'b0;
        end else if (tick) begin
            if (units_wrap) begin
                units <= 4'd0;
                carry <= 1'b1;
                tens  <= tens_wrap ? 4'd0 : tens + 4'd1;
            end else begin
                units <= units + 4'd1;
                carry <= 1'b0;
            end
        end else begin
            carry <= 1'b0;
        end
    end

endmodule

// File: tb/tb_up_count.sv
// tb_up_count: drives four up_count instances with different DIV/MAX from one
// shared clock and reset. Each instance is compared every cycle against an
// arithmetic model. The model derives the digits from the number of clock
// edges since reset was released.
module tb_up_count;

    localparam int N_DUT = 4;
    localparam int DIVS [N_DUT] = '{1, 4, 1, 3};
    localparam int MAXS [N_DUT] = '{9, 9, 5, 15};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] units [N_DUT];
    logic [3:0] tens  [N_DUT];
    logic       carry [N_DUT];

    int tests_run    = 0;
    int tests_failed = 0;
    int n_edges      = 0;  // edges since reset release

    always #5 clk = ~clk;

    up_count #(.DIV(1), .MAX(9)) u_d0 (
        .CLK(clk), .RST(rst), .units(units[0]), .tens(tens[0]), .carry(carry[0]));
    up_count #(.DIV(4), .MAX(9)) u_d1 (
        .CLK(clk), .RST(rst), .units(units[1]), .tens(tens[1]), .carry(carry[1]));
    up_count #(.DIV(1), .MAX(5)) u_d2 (
        .CLK(clk), .RST(rst), .units(units[2]), .tens(tens[2]), .carry(carry[2]));
    up_count #(.DIV(3), .MAX(15)) u_d3 (
        .CLK(clk), .RST(rst), .units(units[3]), .tens(tens[3]), .carry(carry[3]));

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got {carry,tens,units}=%h expected %h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // After n edges, the count has taken floor(n/div) steps. The units digit
    // cycles every mx+1 steps, and tens counts those cycles modulo 10. carry is
    // high only right after a tick edge that brought the units digit back to 0.
    function automatic logic [8:0] model(input int n, input int div, input int mx);
        int   steps;
        int   u;
        int   t;
        logic c;
        steps = n / div;
        u     = steps % (mx + 1);
        t     = (steps / (mx + 1)) % 10;
        c     = (n > 0) && (n % div == 0) && (u == 0);
        return {c, 4'(t), 4'(u)};
    endfunction

    // One clock edge with the given reset level, then check every instance.
    task automatic step(input logic rst_v, input string tag);
        rst = rst_v;
        @(posedge clk);
        if (rst_v) n_edges = 0;
        else       n_edges++;
        #1;
        for (int d = 0; d < N_DUT; d++) begin
            check($sformatf("%s_d%0d_n%0d", tag, d, n_edges),
                  {carry[d], tens[d], units[d]},
                  model(n_edges, DIVS[d], MAXS[d]));
        end
    endtask

    initial begin
        // Hold reset for three edges. Outputs are defined from the first edge onward.
        for (int i = 0; i < 3; i++) step(1'b1, "reset");

        // Long free run: covers the units wrap at 10, the tens wrap at 100
        // (DIV=1), the prescaled wrap at edge 40 (DIV=4), MAX=5, and MAX=15 tens wrap.
        for (int i = 0; i < 500; i++) step(1'b0, "run");

        // Reset mid-count when instance 0 sits at units=9, tens=3 (39 edges after release).
        step(1'b1, "pre_mid");
        for (int i = 0; i < 39; i++) step(1'b0, "to_39");
        step(1'b1, "mid_reset");
        for (int i = 0; i < 20; i++) step(1'b0, "resume");

        // Randomised run with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
